// File: rtl/pipelined_mips_top.sv
// Five-stage MIPS subset core (add/sub/and/or/slt/lw/sw/beq/addi) with forwarding, load-use stall
// and M-stage branch resolution; define MIPS_JUMP_EN to decode j in D.
module pipelined_mips_top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter     IMEM_FILE  = "memfile.dat"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] aluout,
  output logic        memwrite,
  output logic [31:0] pc,
  output logic [31:0] pcn,
  output logic [31:0] instrF,
  output logic [31:0] instrD,
  output logic [31:0] instrE,
  output logic [31:0] instrM,
  output logic [31:0] instrW,
  output logic        ZeroM,
  output logic        BranchM,
  output logic [31:0] PCBranchM,
  output logic        ZeroE,
  output logic        BranchE,
  output logic [31:0] PCBranchE,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic [31:0] SrcAE,
  output logic [31:0] SrcBE,
  output logic [31:0] ALUOutE,
  output logic [31:0] WriteDataE,
  output logic [31:0] SignImmE,
  output logic [4:0]  WriteRegE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E
);
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf [32];

  logic        PCSrcM, stallFD, flushE, jumpD;
  logic [31:0] pcPlus4F, pcPlus4D, pcPlus4E;
  logic [5:0]  opD, functD;
  logic [4:0]  rsD, rtD, rdD, rsE, rtE, rdE, WriteRegM, WriteRegW;
  logic        regWriteD, memtoRegD, memWriteD, branchD, aluSrcD, regDstD, regDstE;
  logic [2:0]  aluCtlD, aluCtlE;
  logic [31:0] signImmD, ALUOutM, WriteDataM, readDataM, ReadDataW, ALUOutW, ResultW;
  logic        RegWriteM, MemtoRegM, MemWriteM, RegWriteW, MemtoRegW;

  // Fetch; a taken M-stage branch overrides both the stall and any D-stage jump.
  assign pcPlus4F = pc + 32'd4;
  assign instrF   = imem[pc[7:2]];
  assign PCSrcM   = BranchM & ZeroM;
`ifdef MIPS_JUMP_EN
  logic [31:0] jumpTargetD;
  assign jumpD       = (instrD[31:26] == 6'b000010);
  assign jumpTargetD = {pcPlus4D[31:28], instrD[25:0], 2'b00};
  assign pcn         = PCSrcM ? PCBranchM : (jumpD ? jumpTargetD : pcPlus4F);
`else
  assign jumpD = 1'b0;
  assign pcn   = PCSrcM ? PCBranchM : pcPlus4F;
`endif

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else if (PCSrcM || !stallFD) pc <= pcn;
  end

  always_ff @(posedge clk) begin
    if (reset || PCSrcM || (jumpD && !stallFD)) begin
      instrD   <= '0;
      pcPlus4D <= '0;
    end else if (!stallFD) begin
      instrD   <= instrF;
      pcPlus4D <= pcPlus4F;
    end
  end

  // Decode
  assign opD      = instrD[31:26];
  assign functD   = instrD[5:0];
  assign rsD      = instrD[25:21];
  assign rtD      = instrD[20:16];
  assign rdD      = instrD[15:11];
  assign signImmD = {{16{instrD[15]}}, instrD[15:0]};

  always_comb begin
    regWriteD = 1'b0;
    memtoRegD = 1'b0;
    memWriteD = 1'b0;
    branchD   = 1'b0;
    aluSrcD   = 1'b0;
    regDstD   = 1'b0;
    aluCtlD   = 3'b010;
    case (opD)
      OP_RTYPE: begin
        regDstD   = 1'b1;
        regWriteD = 1'b1;
        case (functD)
          6'b100000: aluCtlD = 3'b010;
          6'b100010: aluCtlD = 3'b110;
          6'b100100: aluCtlD = 3'b000;
          6'b100101: aluCtlD = 3'b001;
          6'b101010: aluCtlD = 3'b111;
          default:   regWriteD = 1'b0;
        endcase
      end
      OP_LW:   begin regWriteD = 1'b1; memtoRegD = 1'b1; aluSrcD = 1'b1; end
      OP_SW:   begin memWriteD = 1'b1; aluSrcD = 1'b1; end
      OP_BEQ:  begin branchD = 1'b1; aluCtlD = 3'b110; end
      OP_ADDI: begin regWriteD = 1'b1; aluSrcD = 1'b1; end
      default: ;
    endcase
  end

  // Write-before-read: a W-stage write is visible to the D-stage read in the same cycle.
  always_comb begin
    RD1 = rf[rsD];
    RD2 = rf[rtD];
    if (rsD == 5'd0) RD1 = '0;
    else if (RegWriteW && WriteRegW == rsD) RD1 = ResultW;
    if (rtD == 5'd0) RD2 = '0;
    else if (RegWriteW && WriteRegW == rtD) RD2 = ResultW;
  end

  assign stallFD = MemtoRegE & ((rtE == rsD) | (rtE == rtD));
  assign flushE  = stallFD | PCSrcM;

  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      instrE <= '0; RegWriteE <= 1'b0; MemtoRegE <= 1'b0; MemWriteE <= 1'b0;
      BranchE <= 1'b0; ALUSrcE <= 1'b0; regDstE <= 1'b0; aluCtlE <= '0;
      RD1E <= '0; RD2E <= '0; rsE <= '0; rtE <= '0; rdE <= '0;
      SignImmE <= '0; pcPlus4E <= '0;
    end else begin
      instrE <= instrD; RegWriteE <= regWriteD; MemtoRegE <= memtoRegD; MemWriteE <= memWriteD;
      BranchE <= branchD; ALUSrcE <= aluSrcD; regDstE <= regDstD; aluCtlE <= aluCtlD;
      RD1E <= RD1; RD2E <= RD2; rsE <= rsD; rtE <= rtD; rdE <= rdD;
      SignImmE <= signImmD; pcPlus4E <= pcPlus4D;
    end
  end

  // Execute: M-stage result wins over W-stage result when both match.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == rsE) ForwardAE = 2'b10;
    else if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == rsE) ForwardAE = 2'b01;
    if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == rtE) ForwardBE = 2'b10;
    else if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == rtE) ForwardBE = 2'b01;
  end

  always_comb begin
    case (ForwardAE)
      2'b10:   SrcAE = ALUOutM;
      2'b01:   SrcAE = ResultW;
      default: SrcAE = RD1E;
    endcase
    case (ForwardBE)
      2'b10:   WriteDataE = ALUOutM;
      2'b01:   WriteDataE = ResultW;
      default: WriteDataE = RD2E;
    endcase
    SrcBE = ALUSrcE ? SignImmE : WriteDataE;
    case (aluCtlE)
      3'b000:  ALUOutE = SrcAE & SrcBE;
      3'b001:  ALUOutE = SrcAE | SrcBE;
      3'b110:  ALUOutE = SrcAE - SrcBE;
      3'b111:  ALUOutE = {31'd0, $signed(SrcAE) < $signed(SrcBE)};
      default: ALUOutE = SrcAE + SrcBE;
    endcase
  end

  assign ZeroE     = (ALUOutE == 32'd0);
  assign WriteRegE = regDstE ? rdE : rtE;
  assign PCBranchE = {SignImmE[29:0], 2'b00} + pcPlus4E;

  always_ff @(posedge clk) begin
    if (reset || PCSrcM) begin
      instrM <= '0; RegWriteM <= 1'b0; MemtoRegM <= 1'b0; MemWriteM <= 1'b0;
      BranchM <= 1'b0; ZeroM <= 1'b0; ALUOutM <= '0; WriteDataM <= '0;
      WriteRegM <= '0; PCBranchM <= '0;
    end else begin
      instrM <= instrE; RegWriteM <= RegWriteE; MemtoRegM <= MemtoRegE; MemWriteM <= MemWriteE;
      BranchM <= BranchE; ZeroM <= ZeroE; ALUOutM <= ALUOutE; WriteDataM <= WriteDataE;
      WriteRegM <= WriteRegE; PCBranchM <= PCBranchE;
    end
  end

  // Memory
  assign writedata = WriteDataM;
  assign aluout    = ALUOutM;
  assign memwrite  = MemWriteM;
  assign readDataM = dmem[ALUOutM[7:2]];

  always_ff @(posedge clk) begin
    if (MemWriteM) dmem[ALUOutM[7:2]] <= WriteDataM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instrW <= '0; RegWriteW <= 1'b0; MemtoRegW <= 1'b0;
      ReadDataW <= '0; ALUOutW <= '0; WriteRegW <= '0;
    end else begin
      instrW <= instrM; RegWriteW <= RegWriteM; MemtoRegW <= MemtoRegM;
      ReadDataW <= readDataM; ALUOutW <= ALUOutM; WriteRegW <= WriteRegM;
    end
  end

  // Writeback
  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  always_ff @(posedge clk) begin
    if (RegWriteW && WriteRegW != 5'd0) rf[WriteRegW] <= ResultW;
  end
endmodule

// File: tb/tb_pipelined_mips_top.sv
// Directed bench for pipelined_mips_top: forwarding, store, load-use stall, branch squash,
// mid-program reset and the j instruction (taken or nop depending on MIPS_JUMP_EN).
module tb_pipelined_mips_top;
  logic        clk, reset;
  logic [31:0] writedata, aluout, pc, pcn, instrF, instrD, instrE, instrM, instrW;
  logic        memwrite, ZeroM, BranchM, ZeroE, BranchE;
  logic [31:0] PCBranchM, PCBranchE;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
  logic [31:0] SrcAE, SrcBE, ALUOutE, WriteDataE, SignImmE;
  logic [4:0]  WriteRegE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] RD1, RD2, RD1E, RD2E;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int badStores = 0;
  int jumpLeak = 0;

  pipelined_mips_top dut (
    .clk(clk), .reset(reset), .writedata(writedata), .aluout(aluout), .memwrite(memwrite),
    .pc(pc), .pcn(pcn), .instrF(instrF), .instrD(instrD), .instrE(instrE), .instrM(instrM),
    .instrW(instrW), .ZeroM(ZeroM), .BranchM(BranchM), .PCBranchM(PCBranchM), .ZeroE(ZeroE),
    .BranchE(BranchE), .PCBranchE(PCBranchE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUOutE(ALUOutE),
    .WriteDataE(WriteDataE), .SignImmE(SignImmE), .WriteRegE(WriteRegE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .RD1(RD1), .RD2(RD2), .RD1E(RD1E), .RD2E(RD2E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wrong-path store to word 22 and the j delay-slot instruction must never appear.
  always @(negedge clk) begin
    if (!reset && memwrite && aluout == 32'd88) badStores++;
    if (instrE == 32'h200A0003) jumpLeak++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic load_prog(input bit jumpProg);
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
    if (!jumpProg) begin
      dut.imem[0] = 32'h20020005; // addi $2,$0,5
      dut.imem[1] = 32'h2003000C; // addi $3,$0,12
      dut.imem[2] = 32'h00432020; // add  $4,$2,$3
      dut.imem[3] = 32'hAC040054; // sw   $4,84($0)
      dut.imem[4] = 32'h8C050054; // lw   $5,84($0)
      dut.imem[5] = 32'h00A53020; // add  $6,$5,$5
      dut.imem[6] = 32'h10420002; // beq  $2,$2,+2 -> 0x24
      dut.imem[7] = 32'h20070001; // addi $7,$0,1   (squashed)
      dut.imem[8] = 32'hAC020058; // sw   $2,88($0) (squashed)
      dut.imem[9] = 32'h20090009; // addi $9,$0,9   (target)
    end else begin
      dut.imem[8] = 32'h08000000; // j 0
      dut.imem[9] = 32'h200A0003; // addi $10,$0,3
    end
  endtask

  task automatic test_reset();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (instrD !== 32'h0) begin failures++; $display("FAIL reset_instrD: got %h expected 0", instrD); end
    checks++; if (instrE !== 32'h0) begin failures++; $display("FAIL reset_instrE: got %h expected 0", instrE); end
    checks++; if (instrW !== 32'h0) begin failures++; $display("FAIL reset_instrW: got %h expected 0", instrW); end
    checks++; if (memwrite !== 1'b0) begin failures++; $display("FAIL reset_memwrite: got %b expected 0", memwrite); end
    checks++; if (RegWriteE !== 1'b0) begin failures++; $display("FAIL reset_RegWriteE: got %b expected 0", RegWriteE); end
  endtask

  task automatic test_forwarding();
    goto_cycle(4);
    checks++; if (instrE !== 32'h00432020) begin failures++; $display("FAIL fwd_instrE: got %h expected %h", instrE, 32'h00432020); end
    checks++; if (ForwardAE !== 2'b01) begin failures++; $display("FAIL fwd_ForwardAE: got %b expected 01", ForwardAE); end
    checks++; if (ForwardBE !== 2'b10) begin failures++; $display("FAIL fwd_ForwardBE: got %b expected 10", ForwardBE); end
    checks++; if (SrcAE !== 32'd5) begin failures++; $display("FAIL fwd_SrcAE: got %0d expected 5", SrcAE); end
    checks++; if (SrcBE !== 32'd12) begin failures++; $display("FAIL fwd_SrcBE: got %0d expected 12", SrcBE); end
    checks++; if (ALUOutE !== 32'd17) begin failures++; $display("FAIL fwd_ALUOutE: got %0d expected 17", ALUOutE); end
  endtask

  task automatic test_store();
    goto_cycle(5);
    checks++; if (ForwardBE !== 2'b10) begin failures++; $display("FAIL sw_ForwardBE: got %b expected 10", ForwardBE); end
    checks++; if (WriteDataE !== 32'd17) begin failures++; $display("FAIL sw_WriteDataE: got %0d expected 17", WriteDataE); end
    checks++; if (SignImmE !== 32'd84) begin failures++; $display("FAIL sw_SignImmE: got %0d expected 84", SignImmE); end
    goto_cycle(6);
    checks++; if (memwrite !== 1'b1) begin failures++; $display("FAIL sw_memwrite: got %b expected 1", memwrite); end
    checks++; if (aluout !== 32'd84) begin failures++; $display("FAIL sw_aluout: got %0d expected 84", aluout); end
    checks++; if (writedata !== 32'd17) begin failures++; $display("FAIL sw_writedata: got %0d expected 17", writedata); end
  endtask

  task automatic test_load_use();
    goto_cycle(7);
    checks++; if (pc !== 32'h18) begin failures++; $display("FAIL lu_pc_held: got %h expected 18", pc); end
    checks++; if (instrE !== 32'h0) begin failures++; $display("FAIL lu_bubble: got %h expected 0", instrE); end
    checks++; if (instrD !== 32'h00A53020) begin failures++; $display("FAIL lu_instrD: got %h expected %h", instrD, 32'h00A53020); end
    checks++; if (instrM !== 32'h8C050054) begin failures++; $display("FAIL lu_instrM: got %h expected %h", instrM, 32'h8C050054); end
    checks++; if (dut.dmem[21] !== 32'd17) begin failures++; $display("FAIL lu_dmem21: got %0d expected 17", dut.dmem[21]); end
    goto_cycle(8);
    checks++; if (ForwardAE !== 2'b01) begin failures++; $display("FAIL lu_ForwardAE: got %b expected 01", ForwardAE); end
    checks++; if (ForwardBE !== 2'b01) begin failures++; $display("FAIL lu_ForwardBE: got %b expected 01", ForwardBE); end
    checks++; if (ALUOutE !== 32'd34) begin failures++; $display("FAIL lu_ALUOutE: got %0d expected 34", ALUOutE); end
    checks++; if (RD1 !== 32'd5) begin failures++; $display("FAIL lu_RD1: got %0d expected 5", RD1); end
  endtask

  task automatic test_branch();
    goto_cycle(9);
    checks++; if (BranchE !== 1'b1 || ZeroE !== 1'b1) begin failures++; $display("FAIL br_E_flags: got %b%b expected 11", BranchE, ZeroE); end
    checks++; if (PCBranchE !== 32'h24) begin failures++; $display("FAIL br_PCBranchE: got %h expected 24", PCBranchE); end
    goto_cycle(10);
    checks++; if (ZeroM !== 1'b1 || BranchM !== 1'b1) begin failures++; $display("FAIL br_M_flags: got %b%b expected 11", ZeroM, BranchM); end
    checks++; if (PCBranchM !== 32'h24) begin failures++; $display("FAIL br_PCBranchM: got %h expected 24", PCBranchM); end
    checks++; if (pcn !== 32'h24) begin failures++; $display("FAIL br_pcn: got %h expected 24", pcn); end
    goto_cycle(11);
    checks++; if (pc !== 32'h24) begin failures++; $display("FAIL br_pc: got %h expected 24", pc); end
    checks++; if (instrD !== 32'h0 || instrE !== 32'h0 || instrM !== 32'h0) begin failures++; $display("FAIL br_squash: got %h %h %h expected 0 0 0", instrD, instrE, instrM); end
    checks++; if (dut.rf[6] !== 32'd34) begin failures++; $display("FAIL br_rf6: got %0d expected 34", dut.rf[6]); end
    goto_cycle(16);
    checks++; if (dut.rf[9] !== 32'd9) begin failures++; $display("FAIL br_rf9: got %0d expected 9", dut.rf[9]); end
    checks++; if (dut.rf[7] === 32'd1) begin failures++; $display("FAIL br_rf7_written: got %0d expected not 1", dut.rf[7]); end
    checks++; if (badStores !== 0) begin failures++; $display("FAIL br_wrong_path_store: got %0d expected 0", badStores); end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL mr_pc: got %h expected 0", pc); end
    checks++; if ({instrD, instrE, instrM, instrW} !== 128'h0) begin failures++; $display("FAIL mr_instr: got %h %h %h %h expected 0", instrD, instrE, instrM, instrW); end
    checks++; if ({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, BranchM, memwrite} !== 7'b0) begin failures++; $display("FAIL mr_ctrl: got %b expected 0", {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, BranchM, memwrite}); end
    goto_cycle(1);
    checks++; if (pc !== 32'h4 || instrD !== 32'h20020005) begin failures++; $display("FAIL mr_restart: got pc=%h instrD=%h expected 4 20020005", pc, instrD); end
    goto_cycle(6);
    checks++; if (memwrite !== 1'b1 || aluout !== 32'd84) begin failures++; $display("FAIL mr_rerun_sw: got %b %0d expected 1 84", memwrite, aluout); end
    do_reset(1);
    checks++; if (memwrite !== 1'b0 || MemtoRegE !== 1'b0 || instrE !== 32'h0) begin failures++; $display("FAIL mr_busy_reset: got %b %b %h expected 0 0 0", memwrite, MemtoRegE, instrE); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL mr_busy_pc: got %h expected 0", pc); end
  endtask

  task automatic test_jump();
    reset = 1'b1;
    load_prog(1'b1);
    do_reset(2);
    jumpLeak = 0;
`ifdef MIPS_JUMP_EN
    goto_cycle(9);
    checks++; if (instrD !== 32'h08000000 || instrF !== 32'h200A0003) begin failures++; $display("FAIL j_decode: got %h %h expected 08000000 200a0003", instrD, instrF); end
    checks++; if (pcn !== 32'h0) begin failures++; $display("FAIL j_pcn: got %h expected 0", pcn); end
    goto_cycle(10);
    checks++; if (pc !== 32'h0 || instrD !== 32'h0) begin failures++; $display("FAIL j_redirect: got pc=%h instrD=%h expected 0 0", pc, instrD); end
    goto_cycle(40);
    checks++; if (jumpLeak !== 0) begin failures++; $display("FAIL j_slot_leak: got %0d expected 0", jumpLeak); end
`else
    goto_cycle(10);
    checks++; if (pc !== 32'h28) begin failures++; $display("FAIL j_nop_pc: got %h expected 28", pc); end
    goto_cycle(11);
    checks++; if (instrE !== 32'h200A0003) begin failures++; $display("FAIL j_nop_instrE: got %h expected 200a0003", instrE); end
    goto_cycle(14);
    checks++; if (dut.rf[10] !== 32'd3) begin failures++; $display("FAIL j_nop_rf10: got %0d expected 3", dut.rf[10]); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    load_prog(1'b0);
    do_reset(2);
    test_reset();
    test_forwarding();
    test_store();
    test_load_use();
    test_branch();
    test_mid_reset();
    test_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
